// File: rtl/dac_window_agc_pkg.sv
// Shared constants and helpers for the DAC window / AGC path.
package dac_window_agc_pkg;

  localparam int DIST_W     = 8;
  localparam int CLIP_CNT_W = 16;
  localparam int FMT_MAX_W  = 32;

  // Per-cycle action taken on the distance register.
  typedef enum logic [1:0] {
    AGC_HOLD,
    AGC_LOAD,
    AGC_ATTACK,
    AGC_DECAY
  } agc_act_e;

  // Limit a requested window top to the legal range [lo, hi].
  function automatic logic [DIST_W-1:0] clamp_dist(
    input logic [DIST_W-1:0] d,
    input logic [DIST_W-1:0] lo,
    input logic [DIST_W-1:0] hi
  );
    if (d < lo) return lo;
    else if (d > hi) return hi;
    else return d;
  endfunction

  // Two's complement to converter code: offset binary flips the sign bit of a w-bit word.
  function automatic logic [FMT_MAX_W-1:0] to_dac_code(
    input logic [FMT_MAX_W-1:0] v,
    input int                   w,
    input bit                   offset_bin
  );
    return offset_bin ? (v ^ (32'd1 << (w - 1))) : v;
  endfunction

endpackage

// File: rtl/dac_window_agc_round_sat.sv
// Arithmetic right shift with round-half-up and saturation to an OUT_W signed range.
module dac_round_sat
  import dac_window_agc_pkg::*;
#(
  parameter int IN_W  = 28,
  parameter int OUT_W = 14
) (
  input  logic signed [IN_W-1:0]   value,
  input  logic        [DIST_W-1:0] shift,
  output logic signed [OUT_W-1:0]  result,
  output logic                     sat
);

  localparam logic signed [IN_W:0] MAX_V = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] MIN_V = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W:0] ext;
  logic signed [IN_W:0] rnd;
  logic signed [IN_W:0] sum;
  logic signed [IN_W:0] shifted;

  // One guard bit keeps the rounding carry visible so it can saturate instead of wrap.
  always_comb begin
    ext = {value[IN_W-1], value};
    rnd = '0;
    if (shift != '0) rnd = {{IN_W{1'b0}}, 1'b1} << (shift - 8'd1);
    sum     = ext + rnd;
    shifted = sum >>> shift;
    sat     = (shifted > MAX_V) || (shifted < MIN_V);
    if (sat) result = shifted[IN_W] ? MIN_V[OUT_W-1:0] : MAX_V[OUT_W-1:0];
    else     result = shifted[OUT_W-1:0];
  end

endmodule

// File: rtl/dac_window_agc.sv
// DAC window selector: picks an OUT_W-bit window of a wide sample with rounding and
// saturation, formats it for the converter, and optionally auto-ranges the window.
module dac_window_agc
  import dac_window_agc_pkg::*;
#(
  parameter int IN_W       = 28,
  parameter int OUT_W      = 14,
  parameter int WIN_LOG    = 10,
  parameter int OFFSET_BIN = 1
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic signed [IN_W-1:0] DATA_IN,
  input  logic                   data_valid,
  input  logic [DIST_W-1:0]      distance,
  input  logic                   auto_mode,
  output logic [OUT_W-1:0]       DATA_OUT,
  output logic                   out_valid,
  output logic [DIST_W-1:0]      dist_cur,
  output logic                   clip,
  output logic [CLIP_CNT_W-1:0]  clip_cnt
);

  localparam logic [DIST_W-1:0] DIST_MIN = DIST_W'(OUT_W);
  localparam logic [DIST_W-1:0] DIST_MAX = DIST_W'(IN_W);

  logic signed [IN_W-1:0]  data_p1;
  logic                    vld_p1;
  logic [DIST_W-1:0]       dist_p1;
  logic signed [OUT_W-1:0] rs_result;
  logic                    rs_sat;

  logic [WIN_LOG-1:0] win_cnt;
  logic [IN_W-2:0]    peak;
  logic [IN_W-2:0]    abs_in;
  logic [IN_W-2:0]    peak_cand;
  logic [IN_W-1:0]    thr;
  logic               attack;
  logic               win_end;
  agc_act_e           act;

  // Stage 1: capture the sample together with the distance it will be windowed by.
  always_ff @(posedge clk_in) begin
    data_p1 <= DATA_IN;
    dist_p1 <= dist_cur;
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= data_valid;
  end

  dac_round_sat #(.IN_W(IN_W), .OUT_W(OUT_W)) u_round_sat (
    .value  (data_p1),
    .shift  (dist_p1 - DIST_MIN),
    .result (rs_result),
    .sat    (rs_sat)
  );

  // Stage 2: register the formatted code; code and clip hold between valid samples.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      DATA_OUT  <= OUT_W'(to_dac_code('0, OUT_W, OFFSET_BIN != 0));
      out_valid <= 1'b0;
      clip      <= 1'b0;
      clip_cnt  <= '0;
    end else begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        DATA_OUT <= OUT_W'(to_dac_code({{(FMT_MAX_W-OUT_W){1'b0}}, rs_result}, OUT_W,
                                       OFFSET_BIN != 0));
        clip     <= rs_sat;
        if (rs_sat && (clip_cnt != '1)) clip_cnt <= clip_cnt + 1'b1;
      end
    end
  end

  // Magnitude of the incoming sample; the most negative code saturates to the positive max.
  always_comb begin
    abs_in = DATA_IN[IN_W-2:0];
    if (DATA_IN[IN_W-1]) begin
      if (DATA_IN[IN_W-2:0] == '0) abs_in = '1;
      else                         abs_in = ~DATA_IN[IN_W-2:0] + 1'b1;
    end
    peak_cand = (data_valid && (abs_in > peak)) ? abs_in : peak;
    thr       = {{(IN_W-1){1'b0}}, 1'b1} << (dist_cur - 8'd2);
    attack    = auto_mode && vld_p1 && rs_sat;
    win_end   = auto_mode && data_valid && (&win_cnt);
  end

  // Choose the distance action; a clip outranks a window-end decay.
  always_comb begin
    act = AGC_HOLD;
    if (!auto_mode) act = AGC_LOAD;
    else if (attack) act = AGC_ATTACK;
    else if (win_end && ({1'b0, peak_cand} < thr) && (dist_cur > DIST_MIN)) act = AGC_DECAY;
  end

  // Distance register plus the decay window counter and peak tracker.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      dist_cur <= DIST_MAX;
      win_cnt  <= '0;
      peak     <= '0;
    end else begin
      unique case (act)
        AGC_LOAD:   dist_cur <= clamp_dist(distance, DIST_MIN, DIST_MAX);
        AGC_ATTACK: if (dist_cur < DIST_MAX) dist_cur <= dist_cur + 8'd1;
        AGC_DECAY:  dist_cur <= dist_cur - 8'd1;
        default:    ;
      endcase
      if (!auto_mode || attack || win_end) begin
        win_cnt <= '0;
        peak    <= '0;
      end else if (data_valid) begin
        win_cnt <= win_cnt + 1'b1;
        peak    <= peak_cand;
      end
    end
  end

endmodule

// File: tb/tb_dac_window_agc.sv
// Scoreboard bench for dac_window_agc: a driver runs a behavioural model and queues
// expected outputs; a monitor compares them whenever the DUT presents a sample.
module tb_dac_window_agc;

  localparam int IN_W    = 28;
  localparam int OUT_W   = 14;
  localparam int WIN_LOG = 2;
  localparam int HALF    = 1 << (OUT_W - 1);

  logic                   clk_in = 1'b0;
  logic                   reset;
  logic signed [IN_W-1:0] DATA_IN;
  logic                   data_valid;
  logic [7:0]             distance;
  logic                   auto_mode;

  logic [OUT_W-1:0] out_ob, out_tc;
  logic             ov_ob, ov_tc;
  logic [7:0]       dist_ob, dist_tc;
  logic             clip_ob, clip_tc;
  logic [15:0]      cnt_ob, cnt_tc;

  always #5 clk_in = ~clk_in;

  dac_window_agc #(.IN_W(IN_W), .OUT_W(OUT_W), .WIN_LOG(WIN_LOG), .OFFSET_BIN(1)) dut (
    .clk_in(clk_in), .reset(reset), .DATA_IN(DATA_IN), .data_valid(data_valid),
    .distance(distance), .auto_mode(auto_mode), .DATA_OUT(out_ob), .out_valid(ov_ob),
    .dist_cur(dist_ob), .clip(clip_ob), .clip_cnt(cnt_ob));

  dac_window_agc #(.IN_W(IN_W), .OUT_W(OUT_W), .WIN_LOG(WIN_LOG), .OFFSET_BIN(0)) dut_tc (
    .clk_in(clk_in), .reset(reset), .DATA_IN(DATA_IN), .data_valid(data_valid),
    .distance(distance), .auto_mode(auto_mode), .DATA_OUT(out_tc), .out_valid(ov_tc),
    .dist_cur(dist_tc), .clip(clip_tc), .clip_cnt(cnt_tc));

  typedef struct {
    int code_ob;
    int code_tc;
    bit clip;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model state
  int  m_dist;
  int  win_q[$];
  bit  st_v, st_sat;
  bit  m_ov;
  int  issue_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampd(input int d);
    if (d < OUT_W) return OUT_W;
    if (d > IN_W) return IN_W;
    return d;
  endfunction

  function automatic int abs_sat(input longint x);
    if (x == -(longint'(1) << (IN_W - 1))) return (1 << (IN_W - 1)) - 1;
    return (x < 0) ? int'(-x) : int'(x);
  endfunction

  // Windowed value: divide by 2^s rounding half up, then clamp to the code range.
  task automatic predict(input longint x, input int d, output int q, output bit sat);
    int     s;
    longint v;
    s = d - OUT_W;
    v = x;
    if (s > 0) v = v + (longint'(1) << (s - 1));
    v = v >>> s;
    sat = (v > HALF - 1) || (v < -HALF);
    if (v > HALF - 1) v = HALF - 1;
    if (v < -HALF) v = -HALF;
    q = int'(v);
  endtask

  function automatic longint rand_sample(input int kmin);
    longint m;
    int     k;
    k = $urandom_range(IN_W - 1, kmin);
    m = longint'($urandom) & ((longint'(1) << k) - 1);
    if ($urandom_range(1, 0) == 1) m = -m;
    if ($urandom_range(31, 0) == 0) m = -(longint'(1) << (IN_W - 1));
    return m;
  endfunction

  // Apply one cycle of inputs, advance the model across that clock edge, then check.
  task automatic step(input bit rst, input bit dv, input longint x, input int dist_in,
                      input bit am);
    bit     attack, wend, sat;
    int     a, pk, d_old, q;
    exp_t   e;
    reset      = rst;
    data_valid = dv;
    DATA_IN    = x[IN_W-1:0];
    distance   = dist_in[7:0];
    auto_mode  = am;
    if (rst) begin
      exp_q.delete();
      win_q.delete();
      m_dist    = IN_W;
      st_v      = 1'b0;
      st_sat    = 1'b0;
      m_ov      = 1'b0;
      issue_cnt = 0;
    end else begin
      attack = am && st_v && st_sat;
      a      = abs_sat(x);
      wend   = am && dv && (win_q.size() == (1 << WIN_LOG) - 1);
      pk     = a;
      foreach (win_q[i]) if (win_q[i] > pk) pk = win_q[i];
      d_old  = m_dist;
      if (!am) m_dist = clampd(dist_in);
      else if (attack) m_dist = (d_old < IN_W) ? d_old + 1 : d_old;
      else if (wend && (longint'(pk) < (longint'(1) << (d_old - 2))) && d_old > OUT_W)
        m_dist = d_old - 1;
      if (!am || attack || wend) win_q.delete();
      else if (dv) win_q.push_back(a);
      m_ov = st_v;
      if (dv) begin
        predict(x, d_old, q, sat);
        if (sat && issue_cnt < 65535) issue_cnt++;
        e.code_ob = q + HALF;
        e.code_tc = (q < 0) ? q + 2 * HALF : q;
        e.clip    = sat;
        e.cnt     = issue_cnt;
        exp_q.push_back(e);
      end
      st_v   = dv;
      st_sat = dv && sat;
    end
    @(posedge clk_in);
    @(negedge clk_in);
    #1;
    chk("dist_cur", dist_ob, m_dist);
    chk("dist_cur_tc", dist_tc, m_dist);
    chk("out_valid", ov_ob, m_ov);
    chk("out_valid_tc", ov_tc, m_ov);
    if (rst) begin
      chk("reset_data_out", out_ob, HALF);
      chk("reset_data_out_tc", out_tc, 0);
      chk("reset_clip", clip_ob, 0);
      chk("reset_clip_cnt", cnt_ob, 0);
    end
  endtask

  // Monitor: compare each presented sample against the queue; otherwise outputs must hold.
  initial begin
    exp_t last;
    exp_t e;
    last = '{HALF, 0, 1'b0, 0};
    forever begin
      @(negedge clk_in);
      if (reset === 1'b1) begin
        last = '{HALF, 0, 1'b0, 0};
      end else if (ov_ob === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%0d required=none at %0t", out_ob, $time);
        end else begin
          e = exp_q.pop_front();
          chk("data_out", out_ob, e.code_ob);
          chk("data_out_tc", out_tc, e.code_tc);
          chk("clip", clip_ob, e.clip);
          chk("clip_tc", clip_tc, e.clip);
          chk("clip_cnt", cnt_ob, e.cnt);
          chk("clip_cnt_tc", cnt_tc, e.cnt);
          last = e;
        end
      end else begin
        chk("hold_data_out", out_ob, last.code_ob);
        chk("hold_clip", clip_ob, last.clip);
      end
    end
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int     cur_d;
    bit     cur_am;
    int     guard;
    reset = 1'b1; data_valid = 1'b0; DATA_IN = '0; distance = 8'd14; auto_mode = 1'b0;

    repeat (3) step(1, 0, 0, 14, 0);

    // Manual directed cases
    step(0, 0, 0, 14, 0);
    step(0, 1, 5, 14, 0);
    step(0, 0, 0, 14, 0);
    step(0, 0, 0, 20, 0);
    step(0, 1, 288, 20, 0);
    step(0, 1, -288, 20, 0);
    step(0, 0, 0, 14, 0);
    step(0, 1, 20000, 14, 0);
    step(0, 1, -20000, 14, 0);
    step(0, 0, 0, 14, 0);
    step(0, 0, 0, 5, 0);
    step(0, 0, 0, 40, 0);
    step(0, 0, 0, 28, 0);
    step(0, 1, (longint'(1) << 27) - 1, 28, 0);
    step(0, 0, 0, 28, 0);
    step(0, 0, 0, 28, 0);

    // Manual random traffic
    cur_d = 14;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(9, 0) == 0) cur_d = $urandom_range(40, 0);
      step(0, $urandom_range(3, 0) != 0, rand_sample(0), cur_d, 0);
    end

    // Auto from reset with a constant small input: walks down to the floor
    repeat (2) step(1, 0, 0, 0, 1);
    for (int i = 0; i < 70; i++) step(0, 1, 100, 0, 1);

    // Clip on the last sample of a window at the floor
    guard = 0;
    while (win_q.size() != 3 && guard < 8) begin
      step(0, 1, 100, 0, 1);
      guard++;
    end
    step(0, 1, 10000, 0, 1);
    repeat (4) step(0, 1, 100, 0, 1);

    // Reset in the middle of a stream
    step(0, 1, 100, 0, 1);
    step(1, 1, 100, 0, 1);
    step(0, 1, 100, 0, 1);

    // Auto random traffic with occasional mode switches
    cur_d = 20;
    cur_am = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(49, 0) == 0) cur_am = ~cur_am;
      if ($urandom_range(19, 0) == 0) cur_d = $urandom_range(40, 0);
      step(0, $urandom_range(4, 0) != 0, rand_sample(4), cur_d, cur_am);
    end

    repeat (3) step(0, 0, 0, cur_d, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
